// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - 4-digit multiplexed seven-segment driver for the calculator result.
// Latches BCD digits and sign on load, scans common-anode digits, decodes with minus and leading-zero blanking.
module result_display_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic       isNegative,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_e;

  logic [3:0]       d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_e            state_q, state_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic minus3, lead3_zero, blank3, blank2, blank1;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'hF:    s = SEG_MINUS;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    d1_d  = load ? D1 : d1_q;
    d2_d  = load ? D2 : d2_q;
    d3_d  = load ? D3 : d3_q;
    d4_d  = load ? D4 : d4_q;
    neg_d = load ? isNegative : neg_q;

    cnt_d   = cnt_q + CNT_W'(1);
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = scan_e'(state_q + 2'd1);
    end

    // A minus in the thousands position is transparent to blanking of the zeros after it.
    minus3     = neg_q || (d1_q == 4'hF);
    lead3_zero = minus3 || (d1_q == 4'd0);
    blank3     = BLANK_LEADING && !minus3 && (d1_q == 4'd0);
    blank2     = BLANK_LEADING && lead3_zero && (d2_q == 4'd0);
    blank1     = blank2 && (d3_q == 4'd0);

    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (state_q)
      DIG0: begin
        an_d  = 4'b1110;
        seg_d = decode(d4_q);
      end
      DIG1: begin
        an_d  = 4'b1101;
        seg_d = blank1 ? SEG_BLANK : decode(d3_q);
      end
      DIG2: begin
        an_d  = 4'b1011;
        seg_d = blank2 ? SEG_BLANK : decode(d2_q);
      end
      DIG3: begin
        an_d  = 4'b0111;
        seg_d = minus3 ? SEG_MINUS : (blank3 ? SEG_BLANK : decode(d1_q));
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= DIG0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - scoreboard bench for result_display_driver, REFRESH_DIV=4.
// Two instances share inputs: leading-zero blanking on (a) and off (b).
module tb_result_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] D1 = '0, D2 = '0, D3 = '0, D4 = '0;
  logic       isNegative = 1'b0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
  } exp_t;

  exp_t sb[$];

  result_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .isNegative(isNegative), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  result_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .isNegative(isNegative), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release; output after edge n shows digit ((n-1)/DIV)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic do_load(input logic [3:0] v1, v2, v3, v4, input logic neg);
    D1 = v1; D2 = v2; D3 = v3; D4 = v4; isNegative = neg;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    D1 = 4'h8; D2 = 4'h8; D3 = 4'h8; D4 = 4'h8; isNegative = 1'b0;
  endtask

  task automatic expect_scan(input string name,
                             input logic [6:0] a3, a2, a1, a0,
                             input logic [6:0] b3, b2, b1, b0,
                             input int n);
    logic [6:0] ta [4];
    logic [6:0] tb [4];
    exp_t e;
    exp_t got;
    int c, idx;
    ta[0] = a0; ta[1] = a1; ta[2] = a2; ta[3] = a3;
    tb[0] = b0; tb[1] = b1; tb[2] = b2; tb[3] = b3;
    for (int i = 0; i < n; i++) begin
      c = cyc + 1 + i;
      idx = ((c - 1) / DIV) % 4;
      e.cyc = c;
      e.an = ~(4'b0001 << idx);
      e.seg_a = ta[idx];
      e.seg_b = tb[idx];
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      got = sb.pop_front();
      checks++;
      if (cyc !== got.cyc) begin
        errors++;
        $display("FAIL %s align: cycle %0d expected %0d", name, cyc, got.cyc);
      end
      checks++;
      if (an_a !== got.an || an_b !== got.an) begin
        errors++;
        $display("FAIL %s an cyc %0d: got a=%b b=%b expected %b", name, cyc, an_a, an_b, got.an);
      end
      checks++;
      if (seg_a !== got.seg_a) begin
        errors++;
        $display("FAIL %s seg_a cyc %0d: got %b expected %b", name, cyc, seg_a, got.seg_a);
      end
      checks++;
      if (seg_b !== got.seg_b) begin
        errors++;
        $display("FAIL %s seg_b cyc %0d: got %b expected %b", name, cyc, seg_b, got.seg_b);
      end
      checks++;
      if (dp_a !== 1'b1 || dp_b !== 1'b1) begin
        errors++;
        $display("FAIL %s dp: got a=%b b=%b expected 1", name, dp_a, dp_b);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an_a !== 4'b1111 || an_b !== 4'b1111 || seg_a !== 7'h7F || seg_b !== 7'h7F || dp_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got an=%b seg=%b dp=%b expected 1111 1111111 1", an_a, seg_a, dp_a);
    end
    rst_n = 1'b1;
    expect_scan("reset_scan", 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 17);
  endtask

  task automatic test_positive();
    do_load(4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    expect_scan("pos_42", 7'h7F, 7'h7F, 7'h19, 7'h24, 7'h40, 7'h40, 7'h19, 7'h24, 16);
  endtask

  task automatic test_negative();
    do_load(4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
    expect_scan("neg_7", 7'h3F, 7'h7F, 7'h7F, 7'h78, 7'h3F, 7'h40, 7'h40, 7'h78, 16);
  endtask

  task automatic test_all_zero();
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    expect_scan("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 16);
  endtask

  task automatic test_inner_zero();
    do_load(4'd0, 4'd5, 4'd0, 4'd3, 1'b0);
    expect_scan("inner_zero", 7'h7F, 7'h12, 7'h40, 7'h30, 7'h40, 7'h12, 7'h40, 7'h30, 16);
  endtask

  task automatic test_sign_override();
    do_load(4'd9, 4'd0, 4'd0, 4'd1, 1'b1);
    expect_scan("sign_override", 7'h3F, 7'h7F, 7'h7F, 7'h79, 7'h3F, 7'h40, 7'h40, 7'h79, 16);
  endtask

  task automatic test_minus_code_mid_load();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (cyc >= 1 && ((cyc - 1) / DIV) % 4 == 1 && ((cyc - 1) % DIV) == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_dig1_wait: got no DIG1 slot expected one within 40 cycles");
    end
    do_load(4'hF, 4'hA, 4'd3, 4'd1, 1'b0);
    expect_scan("minus_code", 7'h3F, 7'h7F, 7'h30, 7'h79, 7'h3F, 7'h7F, 7'h30, 7'h79, 16);
  endtask

  task automatic test_reset_mid_scan();
    bit found = 1'b0;
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (cyc >= 1 && ((cyc - 1) / DIV) % 4 == 2) found = 1'b1;
    end
    checks++;
    if (!found || an_a !== 4'b1011) begin
      errors++;
      $display("FAIL dig2_before_reset: got an=%b expected 1011", an_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (an_a !== 4'b1111 || seg_a !== 7'h7F || an_b !== 4'b1111 || seg_b !== 7'h7F) begin
      errors++;
      $display("FAIL async_reset: got an=%b seg=%b expected 1111 1111111", an_a, seg_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_scan("after_reset", 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 20);
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_all_zero();
    test_inner_zero();
    test_sign_override();
    test_minus_code_mid_load();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
